// File: rtl/hsi_tx_scheduler.sv
// hsi_tx_scheduler: grants the shared HSI coder to one of five sources, then CRC, then an enforced line gap
module hsi_tx_scheduler #(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic [4:0] req,
  input  logic       msg_end,
  input  logic       crc_done,
  input  logic       cd_busy,
  output logic [5:0] sel,
  output logic [4:0] grant,
  output logic       busy,
  output logic       abort
);
  typedef enum logic [1:0] {IDLE, SEND, CRC, GAP} state_t;
  state_t      state_q;
  logic [5:0]  sel_q;
  logic [4:0]  grant_q;
  logic        busy_q;
  logic        abort_q;
  logic [2:0]  rr_q;
  logic [2:0]  rr_d;
  logic [4:0]  win_d;
  logic [1:0]  p;
  logic [2:0]  idx;
  logic [15:0] wd_q;
  logic [7:0]  gap_q;
  logic        wd_exp;
  logic        gap_last;
  assign sel      = sel_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign abort    = abort_q;
  assign wd_exp   = wd_q == 16'(TIMEOUT - 1);
  assign gap_last = gap_q == 8'(GAP_CYCLES - 1);
  // TM wins outright; otherwise the first request at or after rr_q among 1..4, cyclically
  always_comb begin
    win_d = '0;
    rr_d  = rr_q;
    p     = '0;
    idx   = '0;
    if (req[0]) win_d = 5'b00001;
    else for (int i = 0; i < 4; i++) begin
      p   = rr_q[1:0] + 2'(i) - 2'd1;
      idx = {1'b0, p} + 3'd1;
      if (win_d == '0 && req[idx]) begin
        win_d[idx] = 1'b1;
        rr_d       = (idx == 3'd4) ? 3'd1 : idx + 3'd1;
      end
    end
  end
  // Scheduler FSM with registered outputs, watchdog and gap counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
      rr_q    <= 3'd1;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      grant_q <= '0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: if (en && req != '0) begin
          state_q <= SEND;
          sel_q   <= {1'b0, win_d};
          grant_q <= win_d;
          rr_q    <= rr_d;
          busy_q  <= 1'b1;
          wd_q    <= '0;
        end
        SEND: begin
          wd_q <= wd_q + 16'd1;
          if (msg_end) begin
            state_q <= CRC;
            sel_q   <= 6'b100000;
          end else if (wd_exp) begin
            state_q <= GAP;
            sel_q   <= '0;
            abort_q <= 1'b1;
            gap_q   <= '0;
          end
        end
        CRC: begin
          wd_q <= wd_q + 16'd1;
          if (crc_done || wd_exp) begin
            state_q <= GAP;
            sel_q   <= '0;
            abort_q <= !crc_done;
            gap_q   <= '0;
          end
        end
        default: if (!cd_busy) begin
          if (gap_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else gap_q <= gap_q + 8'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hsi_tx_scheduler.sv
// tb_hsi_tx_scheduler: randomized and directed checks of the scheduler against a transaction-level model
module tb_hsi_tx_scheduler;
  localparam int GAP = 16;
  localparam int TO  = 100;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       en = 1'b0;
  logic [4:0] req = '0;
  logic       msg_end = 1'b0;
  logic       crc_done = 1'b0;
  logic       cd_busy = 1'b0;
  logic [5:0] sel;
  logic [4:0] grant;
  logic       busy;
  logic       abort;
  int errors = 0;
  int checks = 0;
  int rot[$];

  hsi_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .req(req), .msg_end(msg_end),
    .crc_done(crc_done), .cd_busy(cd_busy), .sel(sel), .grant(grant),
    .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rotation list of the non-TM sources: the winner is the first listed source requesting,
  // after which the list is rotated so the source following the winner comes first.
  function automatic int pick(input logic [4:0] r);
    if (r[0]) return 0;
    for (int i = 0; i < 4; i++) begin
      if (r[rot[i]]) begin
        int w;
        w = rot[i];
        repeat (i + 1) rot.push_back(rot.pop_front());
        return w;
      end
    end
    return -1;
  endfunction

  // One message: me = edge (after grant) of msg_end, 0 = never; cd = edges from msg_end to crc_done;
  // cd_busy is held high for st_len cycles after st_at low gap cycles.
  task automatic run(input logic [4:0] r, input int me, input int cd, input int st_at, input int st_len);
    int w, fin, n;
    logic ab;
    logic [5:0] ws, es;
    w  = pick(r);
    ws = 6'd1 << w;
    ab  = (me == 0 || me > TO) || (me < TO && me + cd > TO);
    fin = ab ? TO : me + cd;
    en  = 1'b1;
    req = r;
    step();
    chk("grant", {27'd0, grant}, {27'd0, ws[4:0]});
    chk("sel_grant", {26'd0, sel}, {26'd0, ws});
    chk("busy_send", {31'd0, busy}, 1);
    for (int t = 1; t <= fin; t++) begin
      req      = 5'($urandom);
      en       = 1'($urandom);
      msg_end  = (t == me) || (me != 0 && t > me && $urandom_range(3) == 0);
      crc_done = (me != 0 && t == me + cd) || ((me == 0 || t < me) && $urandom_range(3) == 0);
      step();
      es = (t == fin) ? 6'd0 : ((me != 0 && t >= me) ? 6'b100000 : ws);
      chk("sel_msg", {26'd0, sel}, {26'd0, es});
      chk("abort", {31'd0, abort}, {31'd0, (t == fin) && ab});
      chk("busy_msg", {31'd0, busy}, 1);
      chk("grant_once", {27'd0, grant}, 0);
    end
    msg_end  = 1'b0;
    crc_done = 1'b0;
    n = 0;
    while (busy && n < GAP + st_len + 5) begin
      cd_busy  = (n >= st_at && n < st_at + st_len);
      req      = 5'($urandom);
      en       = 1'($urandom);
      msg_end  = 1'($urandom);
      crc_done = 1'($urandom);
      step();
      n++;
      chk("sel_gap", {26'd0, sel}, 0);
      chk("abort_gap", {31'd0, abort}, 0);
    end
    req      = '0;
    cd_busy  = 1'b0;
    msg_end  = 1'b0;
    crc_done = 1'b0;
    chk("gap_len", n, GAP + st_len);
    chk("idle_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    rot = {1, 2, 3, 4};
    step();
    #2;
    chk("rst_sel", {26'd0, sel}, 0);
    chk("rst_grant", {27'd0, grant}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_abort", {31'd0, abort}, 0);
    step();
    n_rst = 1'b1;
    step();
    chk("idle_sel", {26'd0, sel}, 0);
    chk("idle_busy0", {31'd0, busy}, 0);
    // round robin with wrap: BTC, SR, DPR, CCW, BTC
    repeat (5) run(5'b11110, 4, 2, 0, 0);
    // single SR message, baseline gap
    run(5'b00100, 5, 3, 0, 0);
    // rr pointer now at DPR: TM first, then DPR
    run(5'b11011, 3, 2, 0, 0);
    run(5'b11010, 3, 2, 0, 0);
    // cd_busy held for 20 cycles in mid gap
    run(5'b00010, 5, 3, 4, 20);
    // watchdog: no msg_end; msg_end on expiry; crc_done on expiry
    run(5'b01000, 0, 0, 0, 0);
    run(5'b10000, TO, 4, 0, 0);
    run(5'b00001, TO - 10, 10, 0, 0);
    // CRC expiry with msg_end earlier
    run(5'b00100, 20, 90, 0, 0);
    // en low blocks grants
    en  = 1'b0;
    req = 5'b00001;
    repeat (5) begin
      step();
      chk("en_grant", {27'd0, grant}, 0);
      chk("en_busy", {31'd0, busy}, 0);
    end
    run(5'b00001, 3, 2, 0, 0);
    // asynchronous reset in CRC
    en  = 1'b1;
    req = 5'b11110;
    step();
    req     = '0;
    msg_end = 1'b1;
    step();
    msg_end = 1'b0;
    chk("pre_rst_sel", {26'd0, sel}, 6'b100000);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_sel", {26'd0, sel}, 0);
    chk("arst_grant", {27'd0, grant}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_abort", {31'd0, abort}, 0);
    step();
    n_rst = 1'b1;
    rot = {1, 2, 3, 4};
    step();
    chk("post_rst_abort", {31'd0, abort}, 0);
    run(5'b11110, 4, 2, 0, 0);
    // randomized traffic
    repeat (30) begin
      int me;
      me = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 20));
      run(5'($urandom_range(1, 31)), me, $urandom_range(1, 8), $urandom_range(0, 15), $urandom_range(0, 6));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
